regfile_mp: RTL

- Parametrised successor to the 32x32, 2-read/1-write core register file.
- Adds configurable width and depth, N read ports, and optional registered reads.
- Adds same-cycle write-to-read bypass and an optional hardwired zero register.
- Adds a post-reset clear sequencer that zeroes every entry. Sits in the decode stage between the instruction decoder and the ALU operand muxes, with writeback driving the write port.

---
 rtl/regfile_mp_if.sv | 27 ++
 rtl/regfile_mp.sv | 104 ++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: one write port, NUM_RD packed read ports and
// the clear-sequencer busy flag. The decoder/writeback side uses the master
// modport, the register file uses the slave modport.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_reg;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_reg;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     init_busy;

  modport master (
    output wr_en, wr_reg, wr_data, rd_reg,
    input  rd_data, init_busy
  );

  modport slave (
    input  wr_en, wr_reg, wr_data, rd_reg,
    output rd_data, init_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file for the decode stage.
// After every reset a sequencer zeroes each entry (skipping x0 when it is
// hardwired); reads bypass a same-cycle write and may optionally be
// registered for one cycle of latency.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int READ_LAT = 0,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        clr_idx;
  logic                     init_busy_q;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic                     wr_eff;
  logic [NUM_RD*DATA_W-1:0] rd_next;

  // A write lands only in READY and never on a hardwired x0.
  assign wr_eff = bus.wr_en && (state == READY) &&
                  !((ZERO_REG != 0) && (bus.wr_reg == '0));

  // Clear sequencer: walk FIRST..DEPTH-1 once after each reset, then idle.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_idx     <= FIRST;
      init_busy_q <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST) begin
            state       <= READY;
            init_busy_q <= 1'b0;
          end
        end
        READY: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage update: sequencer zeroing while clearing, writeback otherwise.
  // NOTE: the array has no reset branch so it maps onto plain RAM/flops
  // without reset; the sequencer provides the zeroing instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clr_idx] <= '0;
      else if (wr_eff)
        mem[bus.wr_reg] <= bus.wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;

    assign addr = bus.rd_reg[i*ADDR_W +: ADDR_W];

    // Per-port read value: array, then bypass, then x0/clear masking.
    // NOTE: val gets a default first so no path leaves it unassigned,
    // which keeps this purely combinational (no latch).
    always_comb begin
      val = mem[addr];
      if (wr_eff && (bus.wr_reg == addr))
        val = bus.wr_data;
      if (((ZERO_REG != 0) && (addr == '0)) || (state == CLEAR))
        val = '0;
    end

    assign rd_next[i*DATA_W +: DATA_W] = val;
  end

  if (READ_LAT == 0) begin : g_comb_rd
    assign bus.rd_data = rd_next;
  end else begin : g_reg_rd
    logic [NUM_RD*DATA_W-1:0] rd_q;

    // Registered read: capture the bypassed value so a same-edge write
    // is visible one cycle later.
    always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_next;
    end

    assign bus.rd_data = rd_q;
  end

  assign bus.init_busy = init_busy_q;
endmodule
